// File: rtl/boa_mem_arbiter.sv
// boa_mem_arbiter: shares one downstream memory bus between the instruction
// fetch port (ibus) and the data port (dbus). The data port wins by default.
// A starvation counter hands priority to instruction fetch after it has been
// held off for starve_limit consecutive cycles. The granted request reaches
// the shared bus combinationally, with no added latency. A port that sees
// ready=0 stays locked as owner until its transfer completes.
//
// starve_limit must lie in 1..255.

module boa_mem_arbiter #(
    parameter int unsigned starve_limit = 4
) (
    input  logic        clk,
    input  logic        rst,

    // instruction requester
    input  logic [31:0] ibus_addr,
    input  logic        ibus_re,
    input  logic [3:0]  ibus_we,
    input  logic [31:0] ibus_wdata,
    output logic [31:0] ibus_rdata,
    output logic        ibus_ready,

    // data requester
    input  logic [31:0] dbus_addr,
    input  logic        dbus_re,
    input  logic [3:0]  dbus_we,
    input  logic [31:0] dbus_wdata,
    output logic [31:0] dbus_rdata,
    output logic        dbus_ready,

    // shared downstream bus
    output logic [31:0] sbus_addr,
    output logic        sbus_re,
    output logic [3:0]  sbus_we,
    output logic [31:0] sbus_wdata,
    input  logic [31:0] sbus_rdata,
    input  logic        sbus_ready
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [7:0] STARVE_LIM = 8'(starve_limit);

    owner_e     owner_q, owner_d;
    owner_e     grant;
    logic [7:0] cnt_q, cnt_d;
    logic       ireq, dreq;
    logic       owner_req;

    // Request detection: a port requests when it reads or writes any byte.
    always_comb begin
        ireq = ibus_re || (|ibus_we);
        dreq = dbus_re || (|dbus_we);
    end

    // Grant selection. A locked owner keeps the bus while it still requests.
    // If the owner drops its request, arbitration re-runs in the same cycle.
    always_comb begin
        // NOTE: each signal gets a default on entry so no path leaves it unassigned and no latch is inferred.
        grant     = OWN_NONE;
        owner_req = 1'b0;
        if (owner_q == OWN_I) owner_req = ireq;
        if (owner_q == OWN_D) owner_req = dreq;

        if (owner_req) begin
            grant = owner_q;
        end else if (ireq && (cnt_q >= STARVE_LIM)) begin
            grant = OWN_I;
        end else if (dreq) begin
            grant = OWN_D;
        end else if (ireq) begin
            grant = OWN_I;
        end
    end

    // Forward the granted port onto the shared bus. Read data goes to both
    // ports. Ready goes only to the granted port.
    always_comb begin
        sbus_addr  = 32'h0;
        sbus_re    = 1'b0;
        sbus_we    = 4'h0;
        sbus_wdata = 32'h0;
        ibus_ready = 1'b0;
        dbus_ready = 1'b0;
        ibus_rdata = sbus_rdata;
        dbus_rdata = sbus_rdata;
        case (grant)
            OWN_I: begin
                sbus_addr  = ibus_addr;
                sbus_re    = ibus_re;
                sbus_we    = ibus_we;
                sbus_wdata = ibus_wdata;
                ibus_ready = sbus_ready;
            end
            OWN_D: begin
                sbus_addr  = dbus_addr;
                sbus_re    = dbus_re;
                sbus_we    = dbus_we;
                sbus_wdata = dbus_wdata;
                dbus_ready = sbus_ready;
            end
            default: ;
        endcase
    end

    // Next-state logic. The owner is held through wait states. The starvation
    // counter clears when fetch completes or stops requesting. Otherwise it
    // saturates at 255.
    always_comb begin
        owner_d = OWN_NONE;
        if ((grant != OWN_NONE) && !sbus_ready) owner_d = grant;

        cnt_d = cnt_q;
        if (!ireq || ((grant == OWN_I) && sbus_ready)) begin
            cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State registers with synchronous reset. Reset takes priority over all updates.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
        if (rst) begin
            owner_q <= OWN_NONE;
            cnt_q   <= 8'd0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed testbench for boa_mem_arbiter with starve_limit = 4.
// Inputs are driven 1ns after the rising edge. Outputs are sampled 1ns later.
// That sample point lies well away from the active clock edge.
`timescale 1ns/1ps

module tb_boa_mem_arbiter;

    localparam logic [31:0] I_ADDR  = 32'h4000_0000;
    localparam logic [31:0] D_ADDR  = 32'h8000_0010;
    localparam logic [31:0] D_WDATA = 32'hDEAD_BEEF;
    localparam logic [31:0] I_WDATA = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ibus_addr, ibus_wdata, ibus_rdata;
    logic        ibus_re, ibus_ready;
    logic [3:0]  ibus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic        dbus_re, dbus_ready;
    logic [3:0]  dbus_we;
    logic [31:0] sbus_addr, sbus_wdata, sbus_rdata;
    logic        sbus_re, sbus_ready;
    logic [3:0]  sbus_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    boa_mem_arbiter #(.starve_limit(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_addr  (ibus_addr),
        .ibus_re    (ibus_re),
        .ibus_we    (ibus_we),
        .ibus_wdata (ibus_wdata),
        .ibus_rdata (ibus_rdata),
        .ibus_ready (ibus_ready),
        .dbus_addr  (dbus_addr),
        .dbus_re    (dbus_re),
        .dbus_we    (dbus_we),
        .dbus_wdata (dbus_wdata),
        .dbus_rdata (dbus_rdata),
        .dbus_ready (dbus_ready),
        .sbus_addr  (sbus_addr),
        .sbus_re    (sbus_re),
        .sbus_we    (sbus_we),
        .sbus_wdata (sbus_wdata),
        .sbus_rdata (sbus_rdata),
        .sbus_ready (sbus_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ire, input logic dreq_we, input logic dre_only, input logic rdy);
        ibus_re    = ire;
        ibus_addr  = I_ADDR;
        ibus_we    = 4'h0;
        ibus_wdata = I_WDATA;
        dbus_addr  = D_ADDR;
        dbus_wdata = D_WDATA;
        dbus_we    = dreq_we ? 4'hF : 4'h0;
        dbus_re    = dre_only;
        sbus_ready = rdy;
    endtask

    // Expected grant: 0 none, 1 I, 2 D. Ready expectations follow from it.
    task automatic expect_grant(input string tag, input int g);
        logic [31:0] e_addr, e_wdata;
        logic [31:0] e_re, e_we, e_ir, e_dr;
        #1;
        e_addr = 32'h0; e_wdata = 32'h0; e_re = 0; e_we = 0; e_ir = 0; e_dr = 0;
        if (g == 1) begin
            e_addr = I_ADDR; e_wdata = I_WDATA; e_re = 32'(ibus_re); e_we = 32'(ibus_we);
            e_ir = 32'(sbus_ready);
        end else if (g == 2) begin
            e_addr = D_ADDR; e_wdata = D_WDATA; e_re = 32'(dbus_re); e_we = 32'(dbus_we);
            e_dr = 32'(sbus_ready);
        end
        check({tag, ".addr"},   sbus_addr,         e_addr);
        check({tag, ".re"},     32'(sbus_re),      e_re);
        check({tag, ".we"},     32'(sbus_we),      e_we);
        check({tag, ".wdata"},  sbus_wdata,        e_wdata);
        check({tag, ".iready"}, 32'(ibus_ready),   e_ir);
        check({tag, ".dready"}, 32'(dbus_ready),   e_dr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        sbus_rdata = 32'h1234_5678;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: nothing requests, so the bus is idle.
        expect_grant("reset_idle", 0);
        check("rdata_i", ibus_rdata, 32'h1234_5678);
        check("rdata_d", dbus_rdata, 32'h1234_5678);

        // 1. Instruction-only request completes in the same cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        expect_grant("t1_ionly", 1);
        step();

        // 2/3. Both request with ready=1. D wins for four cycles while cnt climbs 0..3.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        expect_grant("t2_c0_d", 2);
        step();
        expect_grant("t3_c1_d", 2);
        step();
        expect_grant("t3_c2_d", 2);
        step();
        expect_grant("t3_c3_d", 2);
        step();
        // cnt == 4 reaches the limit, so I takes priority.
        expect_grant("t3_c4_i", 1);
        step();
        // I completed, so cnt returned to 0 and D wins again.
        expect_grant("t3_c5_d", 2);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // 4. I locks through three wait states while D rises behind it.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_grant("t4_w0_i", 1);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        expect_grant("t4_w1_lock", 1);
        step();
        expect_grant("t4_w2_lock", 1);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        expect_grant("t4_done_i", 1);
        step();
        expect_grant("t4_next_d", 2);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // 5. D locked in a wait state, then D drops its request. Pending I takes over at once.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_grant("t5_d0", 2);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        expect_grant("t5_dlock", 2);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_grant("t5_release_i", 1);
        step();
        // I is now the owner, because ready was 0. It holds off the returning D.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        expect_grant("t5_ilock", 1);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        expect_grant("t5_idone", 1);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // 6. Reset during a locked I wait state with cnt already past the limit.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        // Owner and cnt are both cleared, so plain D priority applies.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        expect_grant("t6_after_rst_d", 2);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        expect_grant("t6_ionly", 1);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        expect_grant("t6_idle", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
